// File: rtl/ahb_master.sv
// ahb_master
// ----------
// AHB-Lite initiator. Converts a command stream (address, burst type, size,
// length, direction) plus a write-data stream into pipelined AHB-Lite
// transfers, and returns read data as one-cycle pulses.
//
// Ports
//   HCLK, HRESET               bus clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (write, addr, burst, size, len)
//   wdata_valid/wdata_ready    write beat handshake, wdata
//   rdata_valid, rdata         registered read beat
//   done, done_err             end-of-command pulse and its error qualifier
//   HADDR..HWDATA              AHB-Lite address/control/write-data outputs
//   HRDATA, HREADY, HRESP      AHB-Lite slave response inputs
module ahb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_burst,
    input  logic [2:0]            cmd_size,
    input  logic [4:0]            cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdata_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  done_err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam logic [2:0] MAX_SIZE = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_STALL,
        S_LAST,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t state, next_state;

    logic [4:0]            beats_left;
    logic [4:0]            burst_beats;
    logic                  first_beat;
    logic                  dp_valid;
    logic                  dp_write;
    logic [DATA_WIDTH-1:0] wbuf;
    logic                  wbuf_full;

    logic                  accept;
    logic                  issue;
    logic                  advance;
    logic                  last_beat;
    logic                  dp_ok;
    logic                  err_wait;
    logic                  err_done;
    logic [2:0]            size_clamped;
    logic [4:0]            cmd_beats;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  is_wrap;

    assign HPROT = 4'b0011;

    // Command decode: clamp the size to the bus width, align the start
    // address to it, and turn the burst code into a beat count.
    always_comb begin
        size_clamped = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;
        align_mask   = (ADDR_WIDTH'(1) << size_clamped) - ADDR_WIDTH'(1);
        case (cmd_burst)
            3'd0:       cmd_beats = 5'd1;
            3'd1:       cmd_beats = (cmd_len == 5'd0) ? 5'd1 :
                                    (cmd_len > 5'd16) ? 5'd16 : cmd_len;
            3'd2, 3'd3: cmd_beats = 5'd4;
            3'd4, 3'd5: cmd_beats = 5'd8;
            default:    cmd_beats = 5'd16;
        endcase
    end

    // Next beat address. Wrapping bursts keep the upper bits fixed and let
    // only the bits inside the burst-sized window roll over.
    always_comb begin
        is_wrap   = (HBURST == 3'd2) || (HBURST == 3'd4) || (HBURST == 3'd6);
        step      = ADDR_WIDTH'(1) << HSIZE;
        incr_addr = HADDR + step;
        wrap_mask = (ADDR_WIDTH'(burst_beats) << HSIZE) - ADDR_WIDTH'(1);
        next_addr = is_wrap ? ((HADDR & ~wrap_mask) | (incr_addr & wrap_mask))
                            : incr_addr;
    end

    // A transfer can be put on the bus only once its write beat is in hand,
    // either buffered from an earlier handshake or arriving this cycle.
    assign accept    = cmd_valid && cmd_ready;
    assign issue     = ((state == S_ADDR) || (state == S_STALL)) &&
                       (!HWRITE || wbuf_full || wdata_valid);
    assign advance   = issue && HREADY;
    assign last_beat = (beats_left == 5'd1);
    assign dp_ok     = dp_valid && HREADY && !HRESP;
    assign err_wait  = dp_valid && HRESP && !HREADY;
    assign err_done  = dp_valid && HRESP && HREADY;

    // State register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake/transfer-type decode. cmd_ready stays low
    // during the done cycle so a new command starts one cycle later.
    always_comb begin
        next_state  = state;
        HTRANS      = TR_IDLE;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = !done;
                if (accept) next_state = S_ADDR;
            end
            S_ADDR, S_STALL: begin
                wdata_ready = HWRITE && !wbuf_full;
                if (issue)            HTRANS = first_beat ? TR_NONSEQ : TR_SEQ;
                else if (!first_beat) HTRANS = TR_BUSY;
                if (err_wait)         next_state = S_ERR1;
                else if (err_done)    next_state = S_ERR2;
                else if (advance)     next_state = last_beat ? S_LAST : S_ADDR;
                else if (!issue && !first_beat) next_state = S_STALL;
            end
            S_LAST: begin
                if (err_wait)      next_state = S_ERR1;
                else if (err_done) next_state = S_ERR2;
                else if (dp_ok)    next_state = S_IDLE;
            end
            S_ERR1: begin
                if (HREADY) next_state = S_ERR2;
            end
            S_ERR2: begin
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: command latch, beat sequencing, write-data staging, data
    // phase tracking, read capture and completion pulses.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HADDR       <= '0;
            HWRITE      <= 1'b0;
            HSIZE       <= 3'd0;
            HBURST      <= 3'd0;
            HWDATA      <= '0;
            beats_left  <= 5'd0;
            burst_beats <= 5'd0;
            first_beat  <= 1'b0;
            dp_valid    <= 1'b0;
            dp_write    <= 1'b0;
            wbuf        <= '0;
            wbuf_full   <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            done        <= 1'b0;
            done_err    <= 1'b0;
        end else begin
            done        <= 1'b0;
            rdata_valid <= 1'b0;
            if (accept) begin
                HADDR       <= cmd_addr & ~align_mask;
                HWRITE      <= cmd_write;
                HSIZE       <= size_clamped;
                HBURST      <= cmd_burst;
                beats_left  <= cmd_beats;
                burst_beats <= cmd_beats;
                first_beat  <= 1'b1;
            end
            if (advance) begin
                first_beat <= 1'b0;
                beats_left <= beats_left - 5'd1;
                if (!last_beat) HADDR <= next_addr;
                if (HWRITE) HWDATA <= wbuf_full ? wbuf : wdata;
                wbuf_full <= 1'b0;
            end else if (wdata_valid && wdata_ready) begin
                wbuf      <= wdata;
                wbuf_full <= 1'b1;
            end
            if (state == S_ERR1 || state == S_ERR2) wbuf_full <= 1'b0;
            if (HREADY) begin
                dp_valid <= advance;
                dp_write <= HWRITE;
            end
            if (dp_ok && !dp_write && state != S_ERR1) begin
                rdata_valid <= 1'b1;
                rdata       <= HRDATA;
            end
            if (state == S_LAST && dp_ok) begin
                done     <= 1'b1;
                done_err <= 1'b0;
            end
            if (next_state == S_ERR2 && state != S_ERR2) begin
                dp_valid  <= 1'b0;
                wbuf_full <= 1'b0;
                done      <= 1'b1;
                done_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master
// -------------
// Directed bench for ahb_master. The bench plays the slave by driving
// HREADY/HRESP/HRDATA cycle by cycle and checks the bus and stream outputs
// against hand-computed values.
module tb_ahb_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_burst;
    logic [2:0]  cmd_size;
    logic [4:0]  cmd_len;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        done;
    logic        done_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_size(cmd_size),
        .cmd_len(cmd_len), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .wdata(wdata), .rdata_valid(rdata_valid), .rdata(rdata), .done(done),
        .done_err(done_err), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    // Step to just after the next rising edge.
    task automatic nextCycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic setCommand(input logic v, input logic w, input logic [31:0] a,
                              input logic [2:0] b, input logic [2:0] s,
                              input logic [4:0] l);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_burst = b;
        cmd_size  = s;
        cmd_len   = l;
    endtask

    // Drive the write stream and slave response for this cycle, then settle.
    task automatic applyStimulus(input logic wv, input logic [31:0] wd,
                                 input logic hr, input logic rsp,
                                 input logic [31:0] rd);
        wdata_valid = wv;
        wdata       = wd;
        HREADY      = hr;
        HRESP       = rsp;
        HRDATA      = rd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before end of sequence");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        HRESET = 1'b1;
        setCommand(0, 0, 32'h0, 3'd0, 3'd0, 5'd0);
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        #10;
        checkOutput("rst_htrans", HTRANS, 0);
        checkOutput("rst_haddr", HADDR, 0);
        checkOutput("rst_hwrite", HWRITE, 0);
        checkOutput("rst_hsize", HSIZE, 0);
        checkOutput("rst_hburst", HBURST, 0);
        checkOutput("rst_hwdata", HWDATA, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_wdata_ready", wdata_ready, 0);
        checkOutput("rst_rdata_valid", rdata_valid, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_done_err", done_err, 0);
        checkOutput("rst_hprot", HPROT, 4'b0011);
        HRESET = 1'b0;

        // SINGLE word write 0x10 / 0xDEADBEEF
        nextCycle();
        setCommand(1, 1, 32'h10, 3'd0, 3'd2, 5'd0);
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t1_cmd_ready", cmd_ready, 1);
        nextCycle();
        setCommand(0, 0, 32'h0, 3'd0, 3'd0, 5'd0);
        applyStimulus(1, 32'hDEADBEEF, 1, 0, 32'h0);
        checkOutput("t1_nonseq", HTRANS, 2);
        checkOutput("t1_haddr", HADDR, 32'h10);
        checkOutput("t1_hwrite", HWRITE, 1);
        checkOutput("t1_wdata_ready", wdata_ready, 1);
        checkOutput("t1_cmd_ready_busy", cmd_ready, 0);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t1_idle_after", HTRANS, 0);
        checkOutput("t1_hwdata", HWDATA, 32'hDEADBEEF);
        checkOutput("t1_no_early_done", done, 0);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t1_done", done, 1);
        checkOutput("t1_done_err", done_err, 0);
        checkOutput("t1_cmd_ready_done", cmd_ready, 0);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t1_done_pulse", done, 0);
        checkOutput("t1_cmd_ready_back", cmd_ready, 1);

        // INCR4 read from 0x20, one wait state on beat 2 data phase
        setCommand(1, 0, 32'h20, 3'd3, 3'd2, 5'd0);
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        nextCycle();
        setCommand(0, 0, 32'h0, 3'd0, 3'd0, 5'd0);
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t2_b1_trans", HTRANS, 2);
        checkOutput("t2_b1_addr", HADDR, 32'h20);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'hA0A0A0A0);
        checkOutput("t2_b2_trans", HTRANS, 3);
        checkOutput("t2_b2_addr", HADDR, 32'h24);
        nextCycle();
        applyStimulus(0, 32'h0, 0, 0, 32'h0);
        checkOutput("t2_b3_addr", HADDR, 32'h28);
        checkOutput("t2_rv0", rdata_valid, 1);
        checkOutput("t2_rd0", rdata, 32'hA0A0A0A0);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'hA1A1A1A1);
        checkOutput("t2_b3_held", HADDR, 32'h28);
        checkOutput("t2_b3_trans_held", HTRANS, 3);
        checkOutput("t2_no_rv_wait", rdata_valid, 0);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'hA2A2A2A2);
        checkOutput("t2_b4_addr", HADDR, 32'h2C);
        checkOutput("t2_rv1", rdata_valid, 1);
        checkOutput("t2_rd1", rdata, 32'hA1A1A1A1);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'hA3A3A3A3);
        checkOutput("t2_last_idle", HTRANS, 0);
        checkOutput("t2_rd2", rdata, 32'hA2A2A2A2);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t2_rv3", rdata_valid, 1);
        checkOutput("t2_rd3", rdata, 32'hA3A3A3A3);
        checkOutput("t2_done", done, 1);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t2_done_once", done, 0);

        // WRAP4 word write from 0x38
        setCommand(1, 1, 32'h38, 3'd2, 3'd2, 5'd0);
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        nextCycle();
        setCommand(0, 0, 32'h0, 3'd0, 3'd0, 5'd0);
        applyStimulus(1, 32'h11111111, 1, 0, 32'h0);
        checkOutput("t3_b1_trans", HTRANS, 2);
        checkOutput("t3_b1_addr", HADDR, 32'h38);
        checkOutput("t3_hburst", HBURST, 2);
        nextCycle();
        applyStimulus(1, 32'h22222222, 1, 0, 32'h0);
        checkOutput("t3_b2_trans", HTRANS, 3);
        checkOutput("t3_b2_addr", HADDR, 32'h3C);
        checkOutput("t3_d1", HWDATA, 32'h11111111);
        nextCycle();
        applyStimulus(1, 32'h33333333, 1, 0, 32'h0);
        checkOutput("t3_b3_trans", HTRANS, 3);
        checkOutput("t3_b3_wrap", HADDR, 32'h30);
        checkOutput("t3_d2", HWDATA, 32'h22222222);
        nextCycle();
        applyStimulus(1, 32'h44444444, 1, 0, 32'h0);
        checkOutput("t3_b4_trans", HTRANS, 3);
        checkOutput("t3_b4_addr", HADDR, 32'h34);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t3_last_idle", HTRANS, 0);
        checkOutput("t3_d4", HWDATA, 32'h44444444);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t3_done", done, 1);

        // INCR len=3 write, write data missing for two cycles before beat 2
        nextCycle();
        setCommand(1, 1, 32'h40, 3'd1, 3'd2, 5'd3);
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        nextCycle();
        setCommand(0, 0, 32'h0, 3'd0, 3'd0, 5'd0);
        applyStimulus(1, 32'hD0D0D0D0, 1, 0, 32'h0);
        checkOutput("t4_b1_trans", HTRANS, 2);
        checkOutput("t4_b1_addr", HADDR, 32'h40);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t4_busy1", HTRANS, 1);
        checkOutput("t4_busy1_addr", HADDR, 32'h44);
        checkOutput("t4_d0", HWDATA, 32'hD0D0D0D0);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t4_busy2", HTRANS, 1);
        checkOutput("t4_busy2_addr", HADDR, 32'h44);
        checkOutput("t4_hburst_held", HBURST, 1);
        nextCycle();
        applyStimulus(1, 32'hD1D1D1D1, 1, 0, 32'h0);
        checkOutput("t4_b2_seq", HTRANS, 3);
        checkOutput("t4_b2_addr", HADDR, 32'h44);
        checkOutput("t4_b2_wready", wdata_ready, 1);
        nextCycle();
        applyStimulus(1, 32'hD2D2D2D2, 1, 0, 32'h0);
        checkOutput("t4_b3_seq", HTRANS, 3);
        checkOutput("t4_b3_addr", HADDR, 32'h48);
        checkOutput("t4_d1", HWDATA, 32'hD1D1D1D1);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t4_last_idle", HTRANS, 0);
        checkOutput("t4_d2", HWDATA, 32'hD2D2D2D2);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t4_done", done, 1);
        checkOutput("t4_done_err", done_err, 0);

        // INCR8 read, two-cycle ERROR on beat 3
        nextCycle();
        setCommand(1, 0, 32'h100, 3'd5, 3'd2, 5'd0);
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        nextCycle();
        setCommand(0, 0, 32'h0, 3'd0, 3'd0, 5'd0);
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t5_b1_addr", HADDR, 32'h100);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'hE0E0E0E0);
        checkOutput("t5_b2_addr", HADDR, 32'h104);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'hE1E1E1E1);
        checkOutput("t5_rd0", rdata, 32'hE0E0E0E0);
        nextCycle();
        applyStimulus(0, 32'h0, 0, 1, 32'hBADBAD00);
        checkOutput("t5_rv1", rdata_valid, 1);
        checkOutput("t5_rd1", rdata, 32'hE1E1E1E1);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 1, 32'hBADBAD01);
        checkOutput("t5_err_idle", HTRANS, 0);
        checkOutput("t5_no_rv_err", rdata_valid, 0);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t5_done", done, 1);
        checkOutput("t5_done_err", done_err, 1);
        checkOutput("t5_no_rv_err2", rdata_valid, 0);
        checkOutput("t5_idle_after_err", HTRANS, 0);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t5_no_more_beats", HTRANS, 0);
        checkOutput("t5_cmd_ready", cmd_ready, 1);

        // INCR16 read, reset pulsed during beat 5, then a SINGLE read
        setCommand(1, 0, 32'h200, 3'd7, 3'd2, 5'd0);
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            setCommand(0, 0, 32'h0, 3'd0, 3'd0, 5'd0);
            applyStimulus(0, 32'h0, 1, 0, 32'h55550000);
        end
        checkOutput("t6_b5_addr", HADDR, 32'h210);
        HRESET = 1'b1;
        #1;
        checkOutput("t6_rst_htrans", HTRANS, 0);
        checkOutput("t6_rst_haddr", HADDR, 0);
        checkOutput("t6_rst_cmd_ready", cmd_ready, 1);
        checkOutput("t6_rst_rdata_valid", rdata_valid, 0);
        checkOutput("t6_rst_hburst", HBURST, 0);
        HRESET = 1'b0;
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t6_no_done", done, 0);
        checkOutput("t6_still_idle", HTRANS, 0);
        setCommand(1, 0, 32'h0B, 3'd0, 3'd5, 5'd0);
        #1;
        nextCycle();
        setCommand(0, 0, 32'h0, 3'd0, 3'd0, 5'd0);
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t6_single_trans", HTRANS, 2);
        checkOutput("t6_single_align", HADDR, 32'h08);
        checkOutput("t6_size_clamp", HSIZE, 2);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'hCAFEF00D);
        checkOutput("t6_single_idle", HTRANS, 0);
        nextCycle();
        applyStimulus(0, 32'h0, 1, 0, 32'h0);
        checkOutput("t6_rv", rdata_valid, 1);
        checkOutput("t6_rd", rdata, 32'hCAFEF00D);
        checkOutput("t6_done", done, 1);
        checkOutput("t6_done_err", done_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
